// File: rtl/poly_sampler.sv
// Turns PRNG words into uniform/CBD/ternary coefficients for up to NPOLY_MAX polynomials.
// Write appears one cycle after each accepted handshake; rnd_ready is high only in RUN, rnd_valid low stalls.
module poly_sampler #(
    parameter int LOGN      = 13,
    parameter int LOGQ      = 54,
    parameter int RW        = 64,
    parameter int ETA       = 21,
    parameter int CW        = 6,
    parameter int NPOLY_MAX = 4,
    localparam int PW       = (NPOLY_MAX > 1) ? $clog2(NPOLY_MAX) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [PW:0]     num_poly,
    input  logic [LOGQ-1:0] q,
    input  logic [5:0]      shift,
    input  logic [RW-1:0]   rnd_data,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic            wr_en,
    output logic [PW-1:0]   wr_poly,
    output logic [LOGN-1:0] wr_addr,
    output logic [LOGQ-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [15:0]     reject_cnt
);

    localparam int AW = $clog2(ETA + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0]      mode;
        logic [PW:0]     num_poly;
        logic [LOGQ-1:0] q;
        logic [5:0]      shift;
    } cfg_t;

    state_t          state;
    cfg_t            cfg;
    logic [PW-1:0]   poly_cnt;
    logic [LOGN-1:0] addr_cnt;

    logic [LOGQ-1:0] uni_x;
    logic [AW-1:0]   cbd_a;
    logic [AW-1:0]   cbd_b;
    logic [CW-2:0]   cbd_mag;
    logic [15:0]     tern_t;
    logic            coef_ok;
    logic [LOGQ-1:0] coef;

    assign rnd_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Classification uses only latched parameters so input changes mid-run are inert.
    always_comb begin
        uni_x = rnd_data[LOGQ-1:0] >> cfg.shift;
        cbd_a = '0;
        cbd_b = '0;
        for (int i = 0; i < ETA; i++) begin
            cbd_a = cbd_a + AW'(rnd_data[i]);
            cbd_b = cbd_b + AW'(rnd_data[ETA+i]);
        end
        cbd_mag = (cbd_a < cbd_b) ? (CW-1)'(cbd_b - cbd_a) : (CW-1)'(cbd_a - cbd_b);
        tern_t  = rnd_data[RW-1 -: 16];
        coef_ok = 1'b0;
        coef    = '0;
        case (cfg.mode)
            2'd0: begin
                coef_ok = (uni_x < cfg.q);
                coef    = uni_x;
            end
            2'd1: begin
                coef_ok = 1'b1;
                coef    = LOGQ'({cbd_a < cbd_b, cbd_mag});
            end
            2'd2: begin
                coef_ok = (tern_t != 16'hffff);
                if (tern_t < 16'h5555)
                    coef = '0;
                else if (tern_t < 16'haaaa)
                    coef = LOGQ'(1);
                else
                    coef = LOGQ'(3);
            end
            default: begin
                coef_ok = 1'b0;
                coef    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cfg        <= '0;
            poly_cnt   <= '0;
            addr_cnt   <= '0;
            reject_cnt <= '0;
            wr_en      <= 1'b0;
            wr_poly    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cfg        <= {mode, num_poly, q, shift};
                        poly_cnt   <= '0;
                        addr_cnt   <= '0;
                        reject_cnt <= '0;
                        state      <= (num_poly == '0 || mode == 2'd3) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rnd_valid) begin
                        if (coef_ok) begin
                            wr_en    <= 1'b1;
                            wr_poly  <= poly_cnt;
                            wr_addr  <= addr_cnt;
                            wr_data  <= coef;
                            addr_cnt <= addr_cnt + 1'b1;
                            // Last address of a polynomial: move on, or finish on the last one.
                            if (&addr_cnt) begin
                                poly_cnt <= poly_cnt + 1'b1;
                                if ({1'b0, poly_cnt} == cfg.num_poly - 1'b1)
                                    state <= DONE;
                            end
                        end else if (reject_cnt != 16'hffff) begin
                            reject_cnt <= reject_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_sampler.sv
`timescale 1ns/1ps
module tb_poly_sampler;

    localparam int LOGN      = 13;
    localparam int LOGQ      = 54;
    localparam int RW        = 64;
    localparam int ETA       = 21;
    localparam int CW        = 6;
    localparam int NPOLY_MAX = 4;
    localparam int PW        = 2;
    localparam int NCOEF     = 1 << LOGN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = '0;
    logic [PW:0]     num_poly = '0;
    logic [LOGQ-1:0] q = '0;
    logic [5:0]      shift = '0;
    logic [RW-1:0]   rnd_data = '0;
    logic            rnd_valid = 1'b0;
    logic            rnd_ready;
    logic            wr_en;
    logic [PW-1:0]   wr_poly;
    logic [LOGN-1:0] wr_addr;
    logic [LOGQ-1:0] wr_data;
    logic            busy;
    logic            done;
    logic [15:0]     reject_cnt;

    always #5 clk = ~clk;

    poly_sampler #(
        .LOGN(LOGN), .LOGQ(LOGQ), .RW(RW), .ETA(ETA), .CW(CW), .NPOLY_MAX(NPOLY_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_poly(num_poly),
        .q(q), .shift(shift), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .wr_en(wr_en), .wr_poly(wr_poly), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .reject_cnt(reject_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, linear coefficient index into the whole run, reject count.
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    int          m_idx = 0;
    int          m_total = 0;
    int          m_rej = 0;
    int          m_mode = 0;
    logic [63:0] m_q = '0;
    int          m_shift = 0;
    int          m_writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_coef(input int md, input logic [63:0] w, input logic [63:0] qq,
                                     input int sh, output bit ok, output logic [63:0] val);
        logic [63:0] x;
        logic [15:0] t;
        int a;
        int b;
        ok  = 1'b0;
        val = '0;
        case (md)
            0: begin
                x   = (w & ((64'd1 << LOGQ) - 64'd1)) >> sh;
                ok  = (x < qq);
                val = x;
            end
            1: begin
                a   = $countones(w[ETA-1:0]);
                b   = $countones(w[2*ETA-1:ETA]);
                ok  = 1'b1;
                val = (a < b) ? 64'((1 << (CW - 1)) + b - a) : 64'(a - b);
            end
            2: begin
                t   = w[63:48];
                ok  = (t != 16'hffff);
                val = (t < 16'h5555) ? 64'd0 : (t < 16'haaaa) ? 64'd1 : 64'd3;
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // One clock: drive inputs at edge+1, check everything at the following edge+1.
    task automatic cycle(input bit v, input logic [63:0] w, input bit st);
        bit          hs;
        bit          ok;
        bit          take;
        logic [63:0] val;
        int          l_mode;
        int          l_num;
        rnd_valid = v;
        rnd_data  = w;
        start     = st;
        chk("rnd_ready", 64'(rnd_ready), 64'(m_run));
        hs     = v && m_run;
        take   = st && !m_run;
        l_mode = int'(mode);
        l_num  = int'(num_poly);
        ref_coef(m_mode, w, m_q, m_shift, ok, val);
        if (take) begin
            m_q     = 64'(q);
            m_shift = int'(shift);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("wr_en", 64'(wr_en), 64'(hs && ok));
        if (hs && ok) begin
            chk("wr_poly", 64'(wr_poly), 64'(m_idx / NCOEF));
            chk("wr_addr", 64'(wr_addr), 64'(m_idx % NCOEF));
            chk("wr_data", 64'(wr_data), val);
            m_idx++;
            m_writes++;
            if (m_idx == m_total) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (hs && m_rej < 65535) begin
            m_rej++;
        end
        if (take) begin
            m_mode  = l_mode;
            m_total = l_num * NCOEF;
            m_idx   = 0;
            m_rej   = 0;
            m_run   = !(l_num == 0 || l_mode == 3);
            m_done  = !m_run;
        end
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(m_done));
        chk("reject_cnt", 64'(reject_cnt), 64'(m_rej));
    endtask

    task automatic reset_check();
        rst_n     = 1'b0;
        start     = 1'b0;
        rnd_valid = 1'b0;
        #1;
        chk("rst_async_wr_en", 64'(wr_en), 64'd0);
        chk("rst_async_ready", 64'(rnd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({rnd_ready, wr_en, busy, done, wr_poly, wr_addr, reject_cnt}), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        m_run  = 1'b0;
        m_done = 1'b0;
        m_rej  = 0;
        m_idx  = 0;
        m_mode = 0;
        m_q    = '0;
        m_shift = 0;
        rst_n  = 1'b1;
    endtask

    initial begin
        logic [63:0] w;
        logic [21:0] r22;
        logic [47:0] r48;
        logic [15:0] t;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl_init", 64'({rnd_ready, wr_en, busy, done, wr_poly, wr_addr, reject_cnt}), 64'd0);
        chk("rst_data_init", 64'(wr_data), 64'd0);
        rst_n = 1'b1;

        // Uniform with small modulus, then reset after 100 writes.
        mode = 2'd0; num_poly = 3'd1; q = LOGQ'(100); shift = 6'd0;
        cycle(1'b0, 64'($urandom), 1'b1);
        cycle(1'b1, 64'd99, 1'b0);
        cycle(1'b1, 64'd100, 1'b0);
        cycle(1'b1, 64'hffff, 1'b0);
        cycle(1'b1, 64'd5, 1'b0);
        chk("uni_rej_cnt", 64'(reject_cnt), 64'd2);
        for (int g = 0; g < 2000 && m_writes < 100; g++)
            cycle($urandom_range(0, 3) != 0, 64'($urandom_range(0, 199)), 1'b0);
        chk("uni_100_writes", 64'(wr_addr), 64'd99);
        reset_check();
        cycle(1'b1, 64'($urandom), 1'b0);

        // Uniform full run with shift, random stalls, input churn and an ignored start.
        mode = 2'd0; num_poly = 3'd1; shift = 6'd1;
        q = LOGQ'((64'd1 << 53) - 64'($urandom_range(1, 1000)));
        cycle(1'b0, 64'd0, 1'b1);
        for (int n = 0; n < 40000 && m_run; n++) begin
            w = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            cycle($urandom_range(0, 4) != 0, w, $urandom_range(0, 99) == 0);
            mode     = 2'($urandom_range(0, 3));
            num_poly = 3'($urandom_range(0, 4));
            shift    = 6'($urandom_range(0, 63));
            q        = LOGQ'({$urandom, $urandom});
        end
        chk("uni_done", 64'(done), 64'd1);

        // CBD, two polynomials.
        mode = 2'd1; num_poly = 3'd2;
        cycle(1'b0, 64'd0, 1'b1);
        r22 = 22'($urandom);
        cycle(1'b1, {r22, 21'h1f, 21'h7}, 1'b0);
        chk("cbd_neg", 64'(wr_data), 64'b100010);
        r22 = 22'($urandom);
        cycle(1'b1, {r22, 21'h3, 21'h3}, 1'b0);
        chk("cbd_zero", 64'(wr_data), 64'd0);
        for (int n = 0; n < 20000 && m_run; n++) begin
            r22 = 22'($urandom);
            w = (n < 20) ? {$urandom, $urandom} : {r22, 21'h0, 21'h1fffff};
            cycle(1'b1, w, 1'b0);
        end
        chk("cbd_last_data", 64'(wr_data), 64'd21);
        chk("cbd_last_poly", 64'(wr_poly), 64'd1);
        chk("cbd_done", 64'(done), 64'd1);
        chk("cbd_rej", 64'(reject_cnt), 64'd0);

        // Ternary thresholds, toggled valid, ignored start, then completion.
        mode = 2'd2; num_poly = 3'd1;
        cycle(1'b0, 64'd0, 1'b1);
        r48 = 48'({$urandom, $urandom});
        cycle(1'b1, {16'h5554, r48}, 1'b0);
        chk("tern_5554", 64'(wr_data), 64'd0);
        cycle(1'b1, {16'h5555, r48}, 1'b0);
        chk("tern_5555", 64'(wr_data), 64'd1);
        cycle(1'b1, {16'haaaa, r48}, 1'b0);
        chk("tern_aaaa", 64'(wr_data), 64'd3);
        cycle(1'b1, {16'hffff, r48}, 1'b0);
        chk("tern_ffff_no_wr", 64'(wr_en), 64'd0);
        chk("tern_rej", 64'(reject_cnt), 64'd1);
        for (int n = 0; n < 200; n++) begin
            if (n == 51) mode = 2'd0;
            cycle(n % 2 == 0, {$urandom, $urandom}, n == 51);
        end
        mode = 2'd2;
        for (int n = 0; n < 20000 && m_run; n++) begin
            t = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom);
            cycle(1'b1, {t, 48'($urandom)}, 1'b0);
        end
        chk("tern_done", 64'(done), 64'd1);

        // Degenerate runs: zero polynomials, reserved mode.
        mode = 2'd1; num_poly = 3'd0;
        cycle(1'b1, {$urandom, $urandom}, 1'b1);
        chk("deg_done", 64'(done), 64'd1);
        chk("deg_rej_clr", 64'(reject_cnt), 64'd0);
        for (int n = 0; n < 3; n++)
            cycle(1'b1, {$urandom, $urandom}, 1'b0);
        mode = 2'd3; num_poly = 3'd2;
        cycle(1'b1, {$urandom, $urandom}, 1'b1);
        chk("mode3_busy", 64'(busy), 64'd0);
        for (int n = 0; n < 3; n++)
            cycle(1'b1, {$urandom, $urandom}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_sampler.md
# poly_sampler

Parametrised coefficient sampler that turns a stream of PRNG words into polynomial coefficients for one of three distributions (uniform mod q, centred binomial, ternary) and writes them sequentially into up to NPOLY_MAX polynomials of 2^LOGN coefficients. It sits between the Trivium PRNG adapter and the coefficient BRAMs. Compared with the fixed e0/e1/v/pk1 sampler it adds:
- a runtime mode select;
- a runtime polynomial count;
- a valid/ready input handshake;
- a rejection counter.

## Interface
- LOGN, 13, log2 of coefficients per polynomial
- LOGQ, 54, uniform coefficient width; also the width of wr_data
- RW, 64, PRNG word width; must satisfy RW ≥ LOGQ, RW ≥ 2·ETA, RW ≥ 16
- ETA, 21, CBD parameter (bits per half)
- CW, 6, CBD output width; must satisfy CW ≥ clog2(ETA+1)+1
- NPOLY_MAX, 4, maximum polynomials per run; PW = clog2(NPOLY_MAX)

Clocking and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, honoured only in IDLE or DONE
- mode  in  2  0 uniform, 1 CBD, 2 ternary, 3 reserved
- num_poly  in  PW+1  number of polynomials to fill, 0..NPOLY_MAX
- q  in  LOGQ  uniform modulus
- shift  in  6  right shift applied to uniform candidates
- rnd_data  in  RW  PRNG word
- rnd_valid  in  1  rnd_data valid
- rnd_ready  out  1  word consumed when rnd_valid & rnd_ready
- wr_en  out  1  coefficient write strobe
- wr_poly  out  PW  target polynomial index
- wr_addr  out  LOGN  coefficient index
- wr_data  out  LOGQ  coefficient, zero-extended
- busy  out  1  high in RUN
- done  out  1  high in DONE until the next accepted start
- reject_cnt  out  16  rejected words in the current or last run, saturating at 16'hffff

## Operation
FSM states are IDLE, RUN and DONE.
- **IDLE/DONE + start:** latch mode, num_poly, q and shift. Clear the coefficient counter, polynomial counter and reject_cnt.
  - If num_poly == 0 or mode == 3, next state is DONE; no word is consumed and no write occurs.
  - Otherwise next state is RUN.
- **RUN:** rnd_ready = 1, driven combinationally from state. Each handshake word is classified as accept or reject.
  - Accept: a coefficient is written and the counters advance.
  - Reject: reject_cnt increments (saturating); no write occurs and the counters hold.
- **Counters:** {poly, addr}. addr increments per accept. When addr == 2^LOGN−1, addr wraps to 0 and poly increments. The accept of addr = 2^LOGN−1 with poly = num_poly−1 moves the FSM to DONE.
- start in RUN is ignored. Latched parameters are stable for the whole run; input changes during a run have no effect.
- **Uniform:** x = rnd_data[LOGQ-1:0] >> shift. Reject if x ≥ q; otherwise wr_data = x.
- **CBD:** a = popcount(rnd_data[ETA-1:0]), b = popcount(rnd_data[2ETA-1:ETA]). Output is sign-magnitude: wr_data[CW-1] = (a < b), wr_data[CW-2:0] = |a−b|. Zero is encoded +0. Upper bits are 0. CBD never rejects.
- **Ternary:** t = rnd_data[RW-1:RW-16]. Reject if t == 16'hffff. Otherwise wr_data = 0 if t < 16'h5555, 1 if t < 16'haaaa, else 2'b11 (−1). Upper bits are 0.
- **Reset (rst_n low, any time, including mid-run):** state → IDLE. All outputs, counters and reject_cnt → 0, rnd_ready = 0, latched parameters → 0. No partial write occurs after reset.

## Timing
- **Output register:** one pipeline register on wr_en, wr_poly, wr_addr and wr_data. A word handshaken at edge t produces wr_en high in the cycle after t, with the address/poly the counters held at t.
- **Throughput:** one coefficient per cycle while rnd_valid stays high and no rejects occur.
- **Run boundaries:**
  - busy rises in the cycle after start is sampled.
  - On the final accept at edge t, state = DONE in the next cycle. In that same cycle, done = 1, busy = 0, rnd_ready = 0, and the final wr_en is high.
- **Degenerate run:** for num_poly == 0, done is high in the cycle after start is sampled, with no busy cycle.
- **reject_cnt** updates in the cycle after the rejected handshake.
- **Input gaps:** rnd_valid low stalls the block; counters and outputs hold and wr_en = 0.

## Test plan
- **Reset:** assert rst_n = 0 mid-RUN after 100 writes → all outputs 0 in the next cycle. After release plus start, a fresh run starts at poly 0, addr 0.
- **CBD, full length:** mode = 1, num_poly = 2, ETA = 21, words with low 21 bits = 0x1FFFFF and the next 21 bits = 0 → 2·8192 writes, wr_data = 21, addr wraps 8191→0 with wr_poly 0→1. done rises on the same cycle as the last wr_en; reject_cnt = 0.
- **CBD, negative value:** a word giving a = 3, b = 5 → wr_data = 6'b100010.
- **Uniform rejection:** q = 100, shift = 0, words 99, 100, 0xFFFF, 5 → writes 99 at addr 0 and 5 at addr 1; reject_cnt = 2.
- **Ternary thresholds:** t = 0x5554, 0x5555, 0xAAAA, 0xFFFF → writes 0, 1, 3; reject_cnt = 1.
- **Stall and ignored start:** toggle rnd_valid every cycle → wr_en follows each handshake by exactly 1 cycle. A start during RUN leaves the counters unchanged. num_poly = 0 → done in 1 cycle with rnd_ready never high.
